ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the shared RAM.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0 / req1  input  1  access request from port 0 / port 1.
- we0 / we1  input  1  1 = write, 0 = read, per port.
- addr0 / addr1  input  32  byte address per port.
- wdata0 / wdata1  input  32  write data per port.
- gnt0 / gnt1  output  1  port owns the RAM this cycle.
- done0 / done1  output  1  one-cycle completion pulse per port.
- err0 / err1  output  1  valid with done; access rejected.
- rdata  output  32  read result, valid with done.
- mem_a  output  32  RAM byte address.
- mem_wd  output  32  RAM write data.
- mem_we  output  1  RAM write enable.
- mem_rd  input  32  RAM read data.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on any sampled request, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-004 Requests SHALL be sampled only in IDLE; a request raised in ACCESS or RESP SHALL wait for the next IDLE.
REQ-005 In IDLE with both req0 and req1 high, the port not granted most recently SHALL win; with a single request, that port SHALL win.
REQ-006 On leaving IDLE, the block SHALL latch the winner's index, we, addr and wdata, and update the last-grant pointer.
REQ-007 In ACCESS, the block SHALL assert gnt of the winner only, drive mem_a and mem_wd from the latched values, and drive mem_we = latched we AND NOT error.
REQ-008 An access SHALL be in error when addr[1:0] != 0 or addr >= 4*MEM_WORDS.
REQ-009 In ACCESS, the block SHALL register mem_rd into rdata for reads, and SHALL set rdata to 0 for writes and for errors.
REQ-010 In RESP, the block SHALL pulse done of the winner for exactly one cycle and set err to the error flag, with rdata stable.
REQ-011 Latency SHALL be fixed: request sampled in cycle N, gnt in N+1, done in N+2, next sampling in N+3.
REQ-012 The requester SHALL hold req, we, addr and wdata stable until done and drop req the cycle after done; req still high in IDLE SHALL count as a new request.
REQ-013 Outside ACCESS, gnt0, gnt1 and mem_we SHALL be 0, and mem_a and mem_wd SHALL be 0.
REQ-014 Exactly one of gnt0/gnt1 SHALL be high in ACCESS, and both SHALL never be high at once; the same rule SHALL hold for done0/done1.

Reset
REQ-015 When reset is sampled high, the state SHALL become IDLE, all outputs SHALL be 0, and the last-grant pointer SHALL be 1 so that port 0 wins the first tie.
REQ-016 Reset asserted during ACCESS or RESP SHALL abort the transaction, with no done pulse and mem_we 0 from the next cycle.
REQ-017 Reset SHALL take priority over every request.

Structure
REQ-018 The state encoding (IDLE/ACCESS/RESP) and the MEM_WORDS default SHALL be defined in the shared memory package.
REQ-019 The block SHALL instantiate one sub-module, rr_arbiter2, a 2-input round-robin pick with pointer; the RAM itself SHALL stay outside the block.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single read: req0, addr0=0x10, RAM word 4 = 0xDEADBEEF -> gnt0 in cycle N+1, done0 in N+2, rdata=0xDEADBEEF, err0=0.
- Single write: req1, we1=1, addr1=0x20, wdata1=0x12345678 -> mem_we=1 for one cycle, mem_a=0x20; a read of 0x20 then returns 0x12345678.
- Contention: req0 and req1 both held after reset -> grant order 0,1,0,1; done pulses never overlap.
- Misaligned write: addr0=0x13, we0=1 -> mem_we stays 0, done0=1 with err0=1, target word unchanged.
- Out of range read: addr1=0x1000 (MEM_WORDS=1024) -> err1=1, rdata=0.
- Reset in ACCESS: reset asserted the cycle gnt0 is high -> no done0, all outputs 0 the next cycle, and the first subsequent tie goes to port 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, default RAM
// size and the access-legality check.
package ram_arbiter_pkg;

  localparam int MEM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Comparing the word index rather than the byte address avoids overflow when
  // the word count is multiplied by four.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned mem_words);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(mem_words));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick. The pointer holds the most recently granted port
// and advances only when a grant is actually issued.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic any,
  output logic pick
);

  logic last;

  always_comb begin
    any  = req0 | req1;
    pick = (req0 && req1) ? ~last : req1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && any) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port external RAM. Each transaction
// takes a fixed IDLE -> ACCESS -> RESP sequence.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  state_t      state, nxt;
  logic        any, pick;
  logic        win, lat_we, lat_err;
  logic [31:0] lat_addr, lat_wdata;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .advance (state == IDLE),
    .any     (any),
    .pick    (pick)
  );

  always_comb begin
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        win       <= pick;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_err   <= addr_err(sel_addr, MEM_WORDS);
      end
      if (state == ACCESS) begin
        rdata <= (lat_we || lat_err) ? 32'h0 : mem_rd;
      end
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    nxt    = state;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    err0   = 1'b0;
    err1   = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    case (state)
      IDLE: if (any) nxt = ACCESS;
      ACCESS: begin
        nxt    = RESP;
        gnt0   = ~win;
        gnt1   = win;
        mem_a  = lat_addr;
        mem_wd = lat_wdata;
        mem_we = lat_we & ~lat_err;
      end
      RESP: begin
        nxt   = IDLE;
        done0 = ~win;
        done1 = win;
        err0  = ~win & lat_err;
        err1  = win & lat_err;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024-word RAM attached.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] ram [1024];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // External RAM model; a few words are preloaded whenever reset is high.
  assign mem_rd = ram[mem_a[11:2]];
  always @(posedge clk) begin
    if (reset) begin
      ram[0]    <= 32'hFFFF_FFFF;
      ram[4]    <= 32'hDEAD_BEEF;
      ram[1023] <= 32'hA5A5_5A5A;
    end else if (mem_we) begin
      ram[mem_a[11:2]] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " gnt"},    {30'h0, gnt1, gnt0}, 32'h0);
    check({tag, " done"},   {30'h0, done1, done0}, 32'h0);
    check({tag, " err"},    {30'h0, err1, err0}, 32'h0);
    check({tag, " mem_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, " mem_a"},  mem_a, 32'h0);
    check({tag, " mem_wd"}, mem_wd, 32'h0);
    check({tag, " rdata"},  rdata, 32'h0);
  endtask

  task automatic drop_all();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drop_all();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step();
    step();
    check_quiet("reset");
    reset = 1'b0;

    // Single read from port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    step();
    check("rd gnt", {30'h0, gnt1, gnt0}, 32'h1);
    check("rd mem_a", mem_a, 32'h10);
    check("rd mem_we", {31'h0, mem_we}, 32'h0);
    step();
    check("rd done", {30'h0, done1, done0}, 32'h1);
    check("rd err0", {31'h0, err0}, 32'h0);
    check("rd rdata", rdata, 32'hDEAD_BEEF);
    check("rd gnt off", {30'h0, gnt1, gnt0}, 32'h0);
    req0 = 1'b0;
    step();
    check("rd idle done", {30'h0, done1, done0}, 32'h0);

    // Single write from port 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
    step();
    check("wr gnt", {30'h0, gnt1, gnt0}, 32'h2);
    check("wr mem_we", {31'h0, mem_we}, 32'h1);
    check("wr mem_a", mem_a, 32'h20);
    check("wr mem_wd", mem_wd, 32'h1234_5678);
    step();
    check("wr done", {30'h0, done1, done0}, 32'h2);
    check("wr err1", {31'h0, err1}, 32'h0);
    check("wr rdata", rdata, 32'h0);
    check("wr mem_we off", {31'h0, mem_we}, 32'h0);
    check("wr ram", ram[8], 32'h1234_5678);
    drop_all();
    step();
    req0 = 1'b1; addr0 = 32'h20;
    step();
    step();
    check("rdback rdata", rdata, 32'h1234_5678);
    check("rdback done", {30'h0, done1, done0}, 32'h1);
    drop_all();
    step();

    // Contention straight after reset: grants must alternate starting at 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h20;
    for (int i = 0; i < 4; i++) begin
      logic exp1;
      exp1 = logic'(i % 2);
      step();
      check($sformatf("tie%0d gnt", i), {30'h0, gnt1, gnt0}, exp1 ? 32'h2 : 32'h1);
      step();
      check($sformatf("tie%0d done", i), {30'h0, done1, done0}, exp1 ? 32'h2 : 32'h1);
      check($sformatf("tie%0d rdata", i), rdata, exp1 ? 32'h1234_5678 : 32'hDEAD_BEEF);
      step();
      check($sformatf("tie%0d idle", i), {28'h0, done1, done0, gnt1, gnt0}, 32'h0);
    end
    drop_all();
    step();

    // Misaligned write from port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h13; wdata0 = 32'hCAFE_F00D;
    step();
    check("mis gnt", {30'h0, gnt1, gnt0}, 32'h1);
    check("mis mem_we", {31'h0, mem_we}, 32'h0);
    step();
    check("mis done/err", {29'h0, err0, done1, done0}, 32'h5);
    check("mis rdata", rdata, 32'h0);
    check("mis ram", ram[4], 32'hDEAD_BEEF);
    drop_all();
    step();

    // Out-of-range read from port 1, then the last legal word
    req1 = 1'b1; addr1 = 32'h1000;
    step();
    check("oor gnt", {30'h0, gnt1, gnt0}, 32'h2);
    step();
    check("oor done/err", {29'h0, err1, done1, done0}, 32'h6);
    check("oor rdata", rdata, 32'h0);
    drop_all();
    step();
    req1 = 1'b1; addr1 = 32'hFFC;
    step();
    step();
    check("top done/err", {29'h0, err1, done1, done0}, 32'h2);
    check("top rdata", rdata, 32'hA5A5_5A5A);
    drop_all();
    step();

    // Reset during ACCESS aborts; pointer returns so port 0 wins the next tie
    req0 = 1'b1; addr0 = 32'h10;
    step();
    check("abort gnt", {30'h0, gnt1, gnt0}, 32'h1);
    reset = 1'b1;
    step();
    check_quiet("abort");
    reset = 1'b0;
    req1 = 1'b1; addr1 = 32'h20;
    step();
    check("abort tie gnt", {30'h0, gnt1, gnt0}, 32'h1);
    step();
    check("abort tie done", {30'h0, done1, done0}, 32'h1);
    drop_all();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
